// File: rtl/issue_scheduler.sv
// issue_scheduler: in-order issue control for the read/ALU/writeback pipe.
// Holds RAW-hazarded instructions and sequences drain/halt.
module issue_scheduler #(
  parameter int ADDR_W     = 5,
  parameter int OP_W       = 2,
  parameter int PEND_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_dst,
  output logic              iss_valid,
  output logic [OP_W-1:0]   iss_op,
  output logic [ADDR_W-1:0] iss_src1,
  output logic [ADDR_W-1:0] iss_src2,
  output logic [ADDR_W-1:0] iss_dst,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_dst,
  input  logic              drain_req,
  output logic              halted,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PEND_DEPTH-1:0] r_sb_v;
  logic [ADDR_W-1:0]     r_sb_dst [PEND_DEPTH];

  logic              r_iss_valid;
  logic [OP_W-1:0]   r_iss_op;
  logic [ADDR_W-1:0] r_iss_src1;
  logic [ADDR_W-1:0] r_iss_src2;
  logic [ADDR_W-1:0] r_iss_dst;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_hazard;
  logic w_issue;
  logic w_stall;
  logic w_sb_empty;

  // The writeback slot still counts: its result is not yet readable.
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < PEND_DEPTH; k++) begin
      if (r_sb_v[k] &&
          (r_sb_dst[k] == in_src1 ||
           r_sb_dst[k] == in_src2)) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_sb_empty = ~|r_sb_v;

  assign in_ready = !rst &&
                    (r_state == S_RUN) &&
                    !drain_req &&
                    !w_hazard;

  assign w_issue = in_valid && in_ready;

  assign w_stall = (r_state == S_RUN) &&
                   in_valid &&
                   w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_v <= '0;
      for (int k = 0; k < PEND_DEPTH; k++) begin
        r_sb_dst[k] <= '0;
      end
    end else begin
      r_sb_v[0]   <= w_issue;
      r_sb_dst[0] <= w_issue ? in_dst : '0;
      for (int k = 1; k < PEND_DEPTH; k++) begin
        r_sb_v[k]   <= r_sb_v[k-1];
        r_sb_dst[k] <= r_sb_dst[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_src1  <= '0;
      r_iss_src2  <= '0;
      r_iss_dst   <= '0;
    end else begin
      r_iss_valid <= w_issue;
      if (w_issue) begin
        r_iss_op   <= in_op;
        r_iss_src1 <= in_src1;
        r_iss_src2 <= in_src2;
        r_iss_dst  <= in_dst;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An empty scoreboard wins over a dropped request: the drain completes.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        if (drain_req) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_sb_empty)      w_state_nxt = S_HALT;
        else if (!drain_req) w_state_nxt = S_RUN;
      end
      S_HALT: begin
        if (!drain_req) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_issue && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_op    = r_iss_op;
  assign iss_src1  = r_iss_src1;
  assign iss_src2  = r_iss_src2;
  assign iss_dst   = r_iss_dst;
  assign wb_valid  = r_sb_v[PEND_DEPTH-1];
  assign wb_dst    = r_sb_dst[PEND_DEPTH-1];
  assign halted    = (r_state == S_HALT);
  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and random stimulus against a
// busy-until register model, with queue-based issue/writeback checking.
module tb_issue_scheduler;

  localparam int AW  = 5;
  localparam int OW  = 2;
  localparam int PD  = 3;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] in_op = '0;
  logic [AW-1:0] in_src1 = '0;
  logic [AW-1:0] in_src2 = '0;
  logic [AW-1:0] in_dst = '0;
  logic          iss_valid;
  logic [OW-1:0] iss_op;
  logic [AW-1:0] iss_src1;
  logic [AW-1:0] iss_src2;
  logic [AW-1:0] iss_dst;
  logic          wb_valid;
  logic [AW-1:0] wb_dst;
  logic          drain_req = 1'b0;
  logic          halted;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] stall_cnt;

  issue_scheduler #(
    .ADDR_W(AW), .OP_W(OW),
    .PEND_DEPTH(PD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1),
    .in_src2(in_src2), .in_dst(in_dst),
    .iss_valid(iss_valid), .iss_op(iss_op),
    .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_dst(iss_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .drain_req(drain_req), .halted(halted),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            t;
    logic [OW-1:0] op;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
  } iss_t;

  typedef struct {
    int            t;
    logic [AW-1:0] d;
  } wb_t;

  typedef enum {M_RUN, M_DRAIN, M_HALT} mst_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];

  int   busy [32];
  int   last_iss;
  mst_t m_st;
  int   e_iss;
  int   e_stall;
  bit   m_acc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (busy[i]) busy[i] = -1000;
    last_iss = -1000;
    m_st     = M_RUN;
    e_iss    = 0;
    e_stall  = 0;
    m_acc    = 1'b0;
    iss_q.delete();
    wb_q.delete();
  endtask

  // One cycle of the reference model, evaluated mid-cycle.
  task automatic eval();
    int t;
    bit hz;
    bit er;
    t  = cyc;
    hz = (busy[in_src1] >= t) || (busy[in_src2] >= t);
    er = (m_st == M_RUN) && !drain_req && !hz;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("halted", 32'(halted), 32'(m_st == M_HALT));
    chk("issue_cnt", 32'(issue_cnt), e_iss);
    chk("stall_cnt", 32'(stall_cnt), e_stall);
    m_acc = in_valid && er;
    if (m_st == M_RUN && in_valid && hz && e_stall < SAT)
      e_stall++;
    if (m_acc) begin
      iss_q.push_back('{t + 1, in_op, in_src1, in_src2, in_dst});
      wb_q.push_back('{t + PD, in_dst});
      busy[in_dst] = t + PD;
      last_iss = t;
      if (e_iss < SAT) e_iss++;
    end
    case (m_st)
      M_RUN:   if (drain_req) m_st = M_DRAIN;
      M_DRAIN: begin
        if (last_iss + PD < t) m_st = M_HALT;
        else if (!drain_req)   m_st = M_RUN;
      end
      default: if (!drain_req) m_st = M_RUN;
    endcase
  endtask

  task automatic step(input logic v,
                      input logic [OW-1:0] op,
                      input logic [AW-1:0] s1,
                      input logic [AW-1:0] s2,
                      input logic [AW-1:0] d,
                      input logic dr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_op     = op;
    in_src1   = s1;
    in_src2   = s2;
    in_dst    = d;
    drain_req = dr;
    @(negedge clk);
    eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 30, 31, 0, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_iss_op", 32'(iss_op), 0);
    chk("rst_iss_src1", 32'(iss_src1), 0);
    chk("rst_iss_src2", 32'(iss_src2), 0);
    chk("rst_iss_dst", 32'(iss_dst), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_dst", 32'(wb_dst), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_issue_cnt", 32'(issue_cnt), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
  endtask

  // Reset is raised between clock edges, away from any sampling point.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    drain_req = 1'b0;
    #1;
    chk_reset_vals();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    while (iss_q.size() > 0 && iss_q[0].t < cyc) begin
      chk("iss_missing", 32'(iss_q[0].t), 32'(cyc));
      void'(iss_q.pop_front());
    end
    while (wb_q.size() > 0 && wb_q[0].t < cyc) begin
      chk("wb_missing", 32'(wb_q[0].t), 32'(cyc));
      void'(wb_q.pop_front());
    end
    if (iss_valid) begin
      if (iss_q.size() == 0) begin
        chk("iss_unexpected", 32'(iss_valid), 0);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        chk("iss_time", 32'(cyc), 32'(e.t));
        chk("iss_op", 32'(iss_op), 32'(e.op));
        chk("iss_src1", 32'(iss_src1), 32'(e.s1));
        chk("iss_src2", 32'(iss_src2), 32'(e.s2));
        chk("iss_dst", 32'(iss_dst), 32'(e.d));
      end
    end
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 0);
      end else begin
        wb_t w;
        w = wb_q.pop_front();
        chk("wb_time", 32'(cyc), 32'(w.t));
        chk("wb_dst", 32'(wb_dst), 32'(w.d));
      end
    end
  end

  initial begin
    int            i;
    logic          v;
    logic [OW-1:0] op;
    logic [AW-1:0] s1;
    logic [AW-1:0] s2;
    logic [AW-1:0] d;
    logic          dr;
    int            drl;

    model_clear();
    #2;
    chk_reset_vals();
    do_reset();

    // Independent stream
    for (int k = 1; k <= 4; k++)
      step(1, 2'(k), 10, 11, 5'(k), 0);
    idle(5);
    chk("indep_issue_cnt", 32'(issue_cnt), 4);
    chk("indep_stall_cnt", 32'(stall_cnt), 0);

    // RAW on src1, full distance
    do_reset();
    step(1, 1, 1, 2, 7, 0);
    i = 0;
    forever begin
      step(1, 2, 7, 3, 8, 0);
      if (m_acc || i > 10) break;
      i++;
    end
    idle(4);
    chk("raw1_stall_cnt", 32'(stall_cnt), 3);

    // RAW on src2, partial distance, then WAW
    do_reset();
    step(1, 1, 1, 2, 9, 0);
    step(1, 0, 3, 4, 5, 0);
    i = 0;
    forever begin
      step(1, 3, 6, 9, 12, 0);
      if (m_acc || i > 10) break;
      i++;
    end
    step(1, 2, 1, 2, 9, 0);
    chk("waw_ready", 32'(in_ready), 1);
    idle(4);
    chk("raw2_stall_cnt", 32'(stall_cnt), 2);

    // Drain and resume
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1, 1, 10, 11, 5'(k + 1), 0);
    for (i = 0; i <= 10; i++) begin
      step(1, 2, 12, 13, 14, 1);
      if (halted) break;
    end
    chk("drain_halt_bound", 32'(i <= PD + 1), 1);
    step(1, 2, 12, 13, 14, 0);
    step(1, 2, 12, 13, 14, 0);
    chk("resume_ready", 32'(in_ready), 1);
    idle(4);

    // Reset with two instructions pending
    do_reset();
    step(1, 1, 1, 2, 20, 0);
    step(1, 1, 1, 2, 21, 0);
    do_reset();
    step(1, 3, 20, 21, 22, 0);
    chk("post_rst_ready", 32'(in_ready), 1);
    idle(5);
    chk("post_rst_stall", 32'(stall_cnt), 0);

    // Counter saturation
    do_reset();
    for (int k = 0; k < 20; k++)
      step(1, 2'(k), 10, 11, 5'(k % 8), 0);
    idle(4);
    chk("sat_issue_cnt", 32'(issue_cnt), SAT);

    // Random traffic with occasional drains
    do_reset();
    v   = 1'b0;
    op  = '0;
    s1  = '0;
    s2  = '0;
    d   = '0;
    dr  = 1'b0;
    drl = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!v || m_acc) begin
        v  = ($urandom_range(0, 3) != 0);
        op = 2'($urandom);
        s1 = 5'($urandom_range(0, 7));
        s2 = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
      end
      if (drl > 0) begin
        drl--;
      end else begin
        dr  = ($urandom_range(0, 30) == 0);
        drl = dr ? $urandom_range(1, 8) : 0;
      end
      step(v, op, s1, s2, d, dr);
    end
    idle(6);
    chk("iss_q_drained", 32'(iss_q.size()), 0);
    chk("wb_q_drained", 32'(wb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue controller for the three-stage complex-arithmetic pipeline: fetch/address, operand read, ALU/writeback. It accepts decoded instructions (op, two source addresses, one destination address) over a valid/ready handshake and issues them to the operand-read stage. It blocks any instruction whose sources match a destination still in flight (RAW hazard), inserts bubbles, and supports a drain/halt sequence. It owns issue ordering only; it carries no complex data.

## Interface
- `ADDR_W`, default 5: register-file address width (32 complex entries).
- `OP_W`, default 2: ALU opcode width.
- `PEND_DEPTH`, default 3: cycles a destination stays pending after issue (read, ALU, writeback). Must be ≥1.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: a decoded instruction is offered.
- `in_ready`, output, 1: the scheduler accepts it this cycle.
- `in_op`, input, OP_W: ALU opcode.
- `in_src1`, `in_src2`, input, ADDR_W each: source addresses.
- `in_dst`, input, ADDR_W: destination address.
- `iss_valid`, output, 1: registered issue strobe to the operand-read stage.
- `iss_op`, output, OP_W: registered issued opcode.
- `iss_src1`, `iss_src2`, `iss_dst`, output, ADDR_W each: registered issued addresses.
- `wb_valid`, output, 1: the oldest pending slot holds a real instruction; this is its writeback cycle.
- `wb_dst`, output, ADDR_W: destination of that instruction.
- `drain_req`, input, 1: stop accepting instructions and empty the pipeline.
- `halted`, output, 1: FSM is in HALT.
- `issue_cnt`, output, CNT_W: instructions issued, saturating.
- `stall_cnt`, output, CNT_W: hazard-stall cycles, saturating.

## Operation
- **Scoreboard.** A shift register of `PEND_DEPTH` slots, each {v, dst}.
  - Every cycle, slot k moves to slot k+1.
  - Slot 0 loads {1, `in_dst`} on an issue, otherwise {0, x}.
  - The last slot drives `wb_valid`/`wb_dst`.
- **Hazard.** `hazard` = OR over all slots of (v && (dst==`in_src1` || dst==`in_src2`)).
  - All slots count, including the last one (writeback not yet visible to reads).
  - `in_dst` is not compared, so WAW and WAR never stall.
  - Address 0 has no special meaning.
- **Handshake.**
  - `in_ready` = (state==RUN) && !hazard. This is combinational from the inputs and the scoreboard; it may depend on `in_valid`'s payload.
  - issue = `in_valid` && `in_ready`.
  - The requester must hold the payload stable while `in_valid` is high and `in_ready` is low.
- **Issue registers.**
  - `iss_valid` <= issue.
  - `iss_op`/`iss_src*`/`iss_dst` load the `in_*` fields on issue and hold otherwise.
- **FSM** (states RUN, DRAIN, HALT):
  - Reset enters RUN.
  - RUN → DRAIN when `drain_req`=1. `in_ready` is forced to 0 in the same cycle.
  - DRAIN → HALT when all slots have v=0; the check is made on the registered scoreboard.
  - DRAIN → RUN when `drain_req` drops before the scoreboard is empty; the drain is cancelled.
  - HALT → RUN when `drain_req`=0.
  - `halted` = (state==HALT).
- **Counters.**
  - `issue_cnt` increments on issue.
  - `stall_cnt` increments when state==RUN && `in_valid` && hazard.
  - Both saturate at all-ones and never wrap.
- **Reset mid-operation.** Scoreboard, FSM, issue registers and counters all clear immediately. In-flight instructions are forgotten, so the datapath must share `rst`.

## Timing
- **Reset values:** `in_ready`=0 while `rst` is high, then combinational as above. `iss_valid`=0, `iss_*`=0, `wb_valid`=0, `wb_dst`=0, `halted`=0, `issue_cnt`=0, `stall_cnt`=0, all slots v=0.
- **Issue latency:** an instruction accepted in cycle c shows `iss_valid`=1 in cycle c+1. It occupies slot k in cycle c+1+k and shows `wb_valid` in cycle c+`PEND_DEPTH`.
- **Dependency spacing:** a dependent instruction presented in cycle c+1 is accepted no earlier than cycle c+1+`PEND_DEPTH`, i.e. `PEND_DEPTH` stall cycles.
- **Throughput:** independent instructions issue back-to-back at 1 per cycle.
- **Drain:** DRAIN lasts at most `PEND_DEPTH` cycles. `halted` rises the cycle after the last pending slot clears.
- **Simultaneous `drain_req` and an offered instruction in RUN:** the instruction is not accepted.

## Test plan
- **Independent stream.** Four instructions with dst 1,2,3,4 and srcs from {10,11}, `in_valid` held high. Expect `in_ready`=1 every cycle, `iss_valid` high 4 consecutive cycles, `issue_cnt`=4, `stall_cnt`=0, `wb_dst` sequence 1,2,3,4 starting 3 cycles after the first accept.
- **RAW on src1.** A (dst=7) accepted at c0, then B (src1=7) presented at c1. Expect `in_ready`=0 in c1–c3, B accepted in c4, `stall_cnt`=3.
- **RAW on src2 with partial distance.** A (dst=9) at c0, an independent instruction at c1, then C (src2=9) presented at c2. Expect C accepted in c4, `stall_cnt`=2. An instruction whose dst is also 9 (WAW) issues with no stall.
- **Drain.** Issue three independent instructions, then assert `drain_req`. Expect `in_ready`=0 immediately, `halted`=1 after the scoreboard empties (≤3 cycles). Dropping `drain_req` returns to RUN the next cycle and issue resumes.
- **Reset mid-operation.** Assert `rst` asynchronously between edges with two instructions pending. Expect all outputs at their reset values immediately, no `wb_valid` afterwards, and a previously hazarded source accepted with no stall after release.
- **Saturation.** With `CNT_W`=4, issue 20 instructions. Expect `issue_cnt` to hold at 15.
